ieee_to_int_converter: RTL and testbench
========================================

Name: ieee_to_int_converter

Overview:
- Sequential single-precision IEEE754 to signed 32-bit integer converter, the decode direction of the float adder datapath.
- Unpacks sign/exponent/fraction and aligns the significand with an iterative 1-bit/cycle shifter.
- Rounds per the selected mode and saturates out-of-range inputs.
- Valid/ready handshake on both sides; one conversion in flight.

Parameters:
- None. Widths come from the shared single-precision defines: 32-bit number, 8-bit exponent, 23-bit fraction, 32-bit integer result.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  converter idle, can accept
- in_number  input  32  IEEE754 single operand
- round_mode  input  1  0 = round-to-nearest-even, 1 = toward zero; sampled with in_number
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_int  output  32  two's-complement result
- out_invalid  output  1  NaN, Inf or overflow saturation
- out_inexact  output  1  discarded nonzero fraction bits

Behaviour:
- Reset, synchronous, rst high at an edge:
  - state = IDLE; out_valid = 0, out_int = 0, out_invalid = 0, out_inexact = 0.
  - in_ready = 0 in any cycle rst is high.
  - Reset mid-conversion aborts it; the result is lost.
- States: IDLE, SHIFT, ROUND, DONE.
- IDLE, in_ready = 1:
  - Accept on in_valid & in_ready; capture s, e, m, round_mode.
  - Build sig = {1, m} (24 bits), guard g = 0, sticky t = 0.
- Classify at the accepting edge; specials go straight to ROUND with a forced result:
  - e == 255, m != 0 (NaN): 0x7FFFFFFF, invalid = 1.
  - e == 255, m == 0 (Inf): s ? 0x80000000 : 0x7FFFFFFF, invalid = 1.
  - e == 158, s = 1, m = 0: 0x80000000, invalid = 0, exact.
  - Other e >= 158: saturate by sign as for Inf, invalid = 1.
  - e < 126, including zero and denormals: result 0; inexact = (e | m) != 0.
  - 126 <= e <= 149: right shift, n = 150 - e (1..24).
  - e == 150: n = 0, go directly to ROUND.
  - 151 <= e <= 157: left shift, n = e - 150 (1..7).
- SHIFT: one bit per edge, counter n decrements, exit to ROUND when it reaches 0.
  - Right shift: t |= g, g = sig[0], sig >>= 1.
  - Left shift: sig <<= 1 into a 31-bit magnitude register, no overflow possible.
- ROUND, one edge:
  - inc = (round_mode == 0) & g & (t | mag[0]).
  - mag' = mag + inc; out_int = s ? -mag' : mag'.
  - Negative zero becomes 0. inexact = g | t. Then go to DONE.
- DONE:
  - out_valid = 1; out_int and flags held stable until out_valid & out_ready.
  - Then go to IDLE; in_ready is 1 the following cycle.
- Latency: out_valid rises n+1 edges after the accepting edge, with n = 0 for specials. Maximum is 25 edges, at e = 126.
- in_valid while in_ready = 0 is ignored; no queuing.
- RNE tie: exact .5 rounds to the even integer, so 0.5 gives 0 and 1.5 gives 2.

Test Plan:
- 0x3FC00000 (1.5), mode 0 -> out_int 2, inexact = 1, out_valid 24 edges after accept. Mode 1 -> 1, inexact = 1.
- Ties:
  - 0x40200000 (2.5) -> 2.
  - 0xC0600000 (-3.5) -> 0xFFFFFFFC.
  - 0x3F000000 (0.5) -> 0.
  - 0x3F000001 -> 1.
  - 0x80000000 (-0) -> 0, inexact = 0.
- Exact and left shift:
  - 0x4B000001 -> 8388609, exact, 1 edge latency.
  - 0x4EFFFFFF -> 0x7FFFFF80, exact, 8 edges latency.
- Saturation, each with invalid = 1 unless noted:
  - 0x4F000000 -> 0x7FFFFFFF.
  - 0xCF000000 -> 0x80000000, invalid = 0.
  - 0xCF000001 -> 0x80000000.
  - 0x7FC00000 -> 0x7FFFFFFF.
  - 0xFF800000 -> 0x80000000.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles after out_valid -> out_int and flags stable, in_ready = 0, in_valid pulses ignored.
  - Raise out_ready -> in_ready = 1 next cycle; a back-to-back conversion is correct.
- Reset:
  - Assert rst for 1 cycle during SHIFT of 0x3FC00000 -> next cycle IDLE, out_valid = 0, out_int = 0.
  - Next input 0x40400000 -> 3.

Source files
------------

// File: rtl/ieee_to_int_converter.sv
// Single-precision IEEE754 to signed 32-bit integer converter.
// Classifies on accept, aligns one bit per cycle, then rounds (RNE or RTZ) and saturates.
module ieee_to_int_converter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_number,
  input  logic        round_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic        out_invalid,
  output logic        out_inexact,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // out_int and the flags stay frozen while out_valid is high and out_ready is low.

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t state, state_nx;

  logic        sign_q, mode_q, left_q, forced_q, forced_inv_q;
  logic [31:0] forced_val_q;
  logic [30:0] mag_q;
  logic        g_q, t_q;
  logic [4:0]  cnt_q;

  logic [7:0]  exp_in;
  logic [22:0] frac_in;
  logic        cls_forced, cls_inv, cls_t, cls_left;
  logic [31:0] cls_val;
  logic [4:0]  cls_cnt;

  logic        inc;
  logic [31:0] mag_rnd, rnd_res;

  assign exp_in    = in_number[30:23];
  assign frac_in   = in_number[22:0];
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  // Operand classification, used only on the accepting edge.
  always_comb begin
    cls_forced = 1'b0;
    cls_inv    = 1'b0;
    cls_t      = 1'b0;
    cls_left   = 1'b0;
    cls_val    = 32'd0;
    cls_cnt    = 5'd0;
    if (exp_in == 8'd255) begin
      cls_forced = 1'b1;
      cls_inv    = 1'b1;
      cls_val    = ((frac_in != 23'd0) || !in_number[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end else if (exp_in >= 8'd158) begin
      cls_forced = 1'b1;
      if (in_number[31] && exp_in == 8'd158 && frac_in == 23'd0) begin
        cls_val = 32'h8000_0000;
      end else begin
        cls_inv = 1'b1;
        cls_val = in_number[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else if (exp_in < 8'd126) begin
      // Magnitude below 0.5: zero in both modes, inexact unless the operand is a zero.
      cls_forced = 1'b1;
      cls_t      = (exp_in != 8'd0) || (frac_in != 23'd0);
    end else if (exp_in <= 8'd150) begin
      cls_cnt = 5'(8'd150 - exp_in);
    end else begin
      cls_left = 1'b1;
      cls_cnt  = 5'(exp_in - 8'd150);
    end
  end

  always_comb begin
    inc     = !mode_q && g_q && (t_q || mag_q[0]);
    mag_rnd = {1'b0, mag_q} + {31'd0, inc};
    rnd_res = sign_q ? (32'd0 - mag_rnd) : mag_rnd;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = (cls_forced || cls_cnt == 5'd0) ? ROUND : SHIFT;
      SHIFT:   if (cnt_q == 5'd1) state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      out_int      <= 32'd0;
      out_invalid  <= 1'b0;
      out_inexact  <= 1'b0;
      sign_q       <= 1'b0;
      mode_q       <= 1'b0;
      left_q       <= 1'b0;
      forced_q     <= 1'b0;
      forced_inv_q <= 1'b0;
      forced_val_q <= 32'd0;
      mag_q        <= 31'd0;
      g_q          <= 1'b0;
      t_q          <= 1'b0;
      cnt_q        <= 5'd0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (in_valid) begin
          sign_q       <= in_number[31];
          mode_q       <= round_mode;
          left_q       <= cls_left;
          forced_q     <= cls_forced;
          forced_inv_q <= cls_inv;
          forced_val_q <= cls_val;
          mag_q        <= {7'd0, 1'b1, frac_in};
          g_q          <= 1'b0;
          t_q          <= cls_t;
          cnt_q        <= cls_cnt;
        end
        SHIFT: begin
          cnt_q <= cnt_q - 5'd1;
          if (left_q) begin
            mag_q <= mag_q << 1;
          end else begin
            t_q   <= t_q | g_q;
            g_q   <= mag_q[0];
            mag_q <= mag_q >> 1;
          end
        end
        ROUND: begin
          out_int     <= forced_q ? forced_val_q : rnd_res;
          out_invalid <= forced_inv_q;
          out_inexact <= g_q | t_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ieee_to_int_converter.sv
// Bench for ieee_to_int_converter: directed vectors, backpressure, mid-conversion reset
// and randomized operands against an arithmetic reference model.
module tb_ieee_to_int_converter;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, round_mode;
  logic        out_valid, out_ready, out_invalid, out_inexact;
  logic [31:0] in_number, out_int;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ready_mode = 0;

  typedef struct {
    logic [31:0] val;
    logic        inv;
    logic        inx;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  ieee_to_int_converter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_number(in_number), .round_mode(round_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_int(out_int), .out_invalid(out_invalid),
    .out_inexact(out_inexact), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: exact value sig * 2^(e-150), rounded by comparing the remainder with one half.
  function automatic exp_t model(input logic [31:0] x, input logic mode);
    exp_t   r;
    logic   s;
    int     e, n;
    longint sig, mag, rem, half;
    logic [31:0] m32;
    s = x[31];
    e = int'(x[30:23]);
    sig = longint'({1'b1, x[22:0]});
    r.val = 32'd0; r.inv = 1'b0; r.inx = 1'b0; r.lat = 1; r.acc = 0;
    if (e == 255) begin
      r.inv = 1'b1;
      r.val = (x[22:0] != 0 || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
      return r;
    end
    if (e >= 158) begin
      if (s && e == 158 && x[22:0] == 0) r.val = 32'h8000_0000;
      else begin
        r.inv = 1'b1;
        r.val = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      return r;
    end
    if (e < 126) begin
      r.inx = (x[30:0] != 0);
      return r;
    end
    if (e >= 150) begin
      mag = sig << (e - 150);
      r.lat = e - 150 + 1;
    end else begin
      n = 150 - e;
      mag = sig >> n;
      rem = sig - (mag << n);
      half = longint'(1) << (n - 1);
      r.inx = (rem != 0);
      if (!mode && (rem > half || (rem == half && mag % 2 == 1))) mag = mag + 1;
      r.lat = n + 1;
    end
    m32 = mag[31:0];
    r.val = s ? (32'd0 - m32) : m32;
    return r;
  endfunction

  function automatic logic [31:0] rand_num();
    logic [7:0]  e;
    logic [22:0] m;
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 5)       e = 8'($urandom_range(120, 160));
    else if (sel == 5) e = 8'd255;
    else if (sel == 6) e = 8'($urandom_range(0, 125));
    else if (sel == 7) e = 8'($urandom_range(155, 159));
    else               e = 8'($urandom_range(0, 255));
    m = 23'($urandom);
    if ($urandom_range(0, 3) == 0) m = m & 23'h7F_0000;
    if ($urandom_range(0, 7) == 0) m = 23'd0;
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  // Driver: wait for in_ready, present one word for one edge, queue its expectation.
  task automatic convert(input logic [31:0] x, input logic mode);
    exp_t ex;
    bit got;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1; in_number = x; round_mode = mode;
    ex = model(x, mode);
    ex.acc = cyc + 1;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_number = $urandom; round_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // Random consumer backpressure unless a test owns out_ready.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard: every cycle a result is presented it must match the queue head.
  bit prev_valid = 0;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        check("out_int", out_int, exp_q[0].val);
        check("out_invalid", 32'(out_invalid), 32'(exp_q[0].inv));
        check("out_inexact", 32'(out_inexact), 32'(exp_q[0].inx));
        if (!prev_valid) check("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    prev_valid = out_valid && !rst;
  end

  logic [31:0] pin_x   [14] = '{32'h3FC00000, 32'h3FC00000, 32'h40200000, 32'hC0600000,
                                32'h3F000000, 32'h3F000001, 32'h80000000, 32'h4B000001,
                                32'h4EFFFFFF, 32'h4F000000, 32'hCF000000, 32'hCF000001,
                                32'h7FC00000, 32'hFF800000};
  logic        pin_mode[14] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic [31:0] pin_val [14] = '{32'd2, 32'd1, 32'd2, 32'hFFFFFFFC, 32'd0, 32'd1, 32'd0,
                                32'd8388609, 32'h7FFFFF80, 32'h7FFFFFFF, 32'h80000000,
                                32'h80000000, 32'h7FFFFFFF, 32'h80000000};
  logic        pin_inv [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1};
  logic        pin_inx [14] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int          pin_lat [14] = '{24, 24, 23, 23, 25, 25, 1, 1, 8, 1, 1, 1, 1, 1};

  initial begin
    exp_t pm;
    rst = 1'b1; in_valid = 1'b0; in_number = 32'd0; round_mode = 1'b0;

    for (int i = 0; i < 14; i++) begin
      pm = model(pin_x[i], pin_mode[i]);
      check($sformatf("pin_val_%0d", i), pm.val, pin_val[i]);
      check($sformatf("pin_inv_%0d", i), 32'(pm.inv), 32'(pin_inv[i]));
      check($sformatf("pin_inx_%0d", i), 32'(pm.inx), 32'(pin_inx[i]));
      check($sformatf("pin_lat_%0d", i), 32'(pm.lat), 32'(pin_lat[i]));
    end

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_int", out_int, 32'd0);
    check("rst_out_invalid", 32'(out_invalid), 32'd0);
    check("rst_out_inexact", 32'(out_inexact), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) convert(pin_x[i], pin_mode[i]);
    drain();

    // Backpressure: result frozen, in_ready low, in_valid pulses ignored.
    ready_mode = 1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    convert(32'h40200000, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      in_valid = 1'b1; in_number = 32'h3F800000;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_out_valid_after", 32'(out_valid), 32'd0);
    ready_mode = 0;
    convert(32'h40400000, 1'b0);
    convert(32'hC0200000, 1'b0);
    drain();

    // Reset in the middle of a SHIFT phase.
    convert(32'h3FC00000, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1 check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_int", out_int, 32'd0);
    check("midrst_in_ready_idle", 32'(in_ready), 32'd1);
    convert(32'h40400000, 1'b0);
    drain();

    for (int i = 0; i < 300; i++) begin
      convert(rand_num(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
